// File: rtl/gpio_port_int_if.sv
// Register-bus side of the port interrupt block: PxIFG write/IV-read strobes and the
// flag, vector and request results that the CPU and bus read back.
interface gpio_port_int_if #(parameter int WIDTH = 8);
   // Strobes are single-cycle qualifiers sampled on the MCLK rising edge; the slave is
   // always ready, so there is no backpressure and every asserted strobe takes effect.
   logic             ifg_we;
   logic [WIDTH-1:0] ifg_wdata;
   logic             iv_rd;
   logic [WIDTH-1:0] PxIFG;
   logic [15:0]      PxIV;
   logic             IRQ;

   modport master (output ifg_we, ifg_wdata, iv_rd, input PxIFG, PxIV, IRQ);
   modport slave  (input ifg_we, ifg_wdata, iv_rd, output PxIFG, PxIV, IRQ);
endinterface

// File: rtl/gpio_port_int.sv
// GPIO port input synchroniser, edge detector, PxIFG flags and PxIV priority vector.
// Optional glitch filter between sync2 and the edge logic: define PORT_INT_FILTER_EN.
module gpio_port_int #(
   parameter int WIDTH      = 8,
   parameter int FILTER_LEN = 3
) (
   input  logic             MCLK,
   input  logic             RST_n,
   input  logic [WIDTH-1:0] PxIN,
   input  logic [WIDTH-1:0] PxIES,
   input  logic [WIDTH-1:0] PxIE,
   gpio_port_int_if.slave   bus
);

   if (WIDTH < 1 || WIDTH > 8 || FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_params
      $error("gpio_port_int: WIDTH must be 1..8 and FILTER_LEN 2..15");
   end

   logic [WIDTH-1:0] sync1, sync2, prev, ifg, ifg_next;
   logic [WIDTH-1:0] cur, rise, fall, edge_hit, qual, sel;
   logic [15:0]      iv;
   logic             det_en;

`ifdef PORT_INT_FILTER_EN
   localparam int WARM_MAX = FILTER_LEN + 3;
   localparam int CW       = $clog2(FILTER_LEN + 1);

   logic [4:0]       warm;
   logic [WIDTH-1:0] filt;
   logic [CW-1:0]    stab [WIDTH];

   // A new level is accepted only after FILTER_LEN consecutive edges away from filt.
   always_ff @(posedge MCLK) begin
      if (!RST_n) begin
         warm <= '0;
         filt <= '0;
         for (int i = 0; i < WIDTH; i++) stab[i] <= '0;
      end else begin
         if (warm != 5'(WARM_MAX)) warm <= warm + 5'd1;
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] != filt[i]) begin
               if (stab[i] == CW'(FILTER_LEN - 1)) begin
                  filt[i] <= sync2[i];
                  stab[i] <= '0;
               end else begin
                  stab[i] <= stab[i] + 1'b1;
               end
            end else begin
               stab[i] <= '0;
            end
         end
      end
   end

   assign cur    = filt;
   assign det_en = (warm == 5'(WARM_MAX));
`else
   logic [1:0] warm;

   always_ff @(posedge MCLK) begin
      if (!RST_n)              warm <= '0;
      else if (warm != 2'd3)   warm <= warm + 2'd1;
   end

   assign cur    = sync2;
   assign det_en = (warm == 2'd3);
`endif

   always_ff @(posedge MCLK) begin
      if (!RST_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         ifg   <= '0;
      end else begin
         sync1 <= PxIN;
         sync2 <= sync1;
         prev  <= cur;
         ifg   <= ifg_next;
      end
   end

   assign rise     = cur & ~prev;
   assign fall     = ~cur & prev;
   assign edge_hit = det_en ? ((PxIES & fall) | (~PxIES & rise)) : '0;
   assign qual     = ifg & PxIE;

   // Scanning from the top down leaves the lowest qualifying bit as the winner.
   always_comb begin
      iv  = '0;
      sel = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (qual[i]) begin
            iv  = 16'(2 * (i + 1));
            sel = WIDTH'(1) << i;
         end
      end
   end

   always_comb begin
      ifg_next = ifg;
      for (int i = 0; i < WIDTH; i++) begin
         if (edge_hit[i])                ifg_next[i] = 1'b1;
         else if (bus.ifg_we)            ifg_next[i] = bus.ifg_wdata[i];
         else if (bus.iv_rd && sel[i])   ifg_next[i] = 1'b0;
      end
   end

   assign bus.PxIFG = ifg;
   assign bus.PxIV  = iv;
   assign bus.IRQ   = |qual;

endmodule

// File: tb/tb_gpio_port_int.sv
// Scoreboard bench for gpio_port_int: a pin-history reference model pushes the expected
// PxIFG/PxIV/IRQ per cycle; a monitor pops and compares after each rising edge.
module tb_gpio_port_int;
   localparam int W  = 8;
   localparam int FL = 3;
   localparam int HD = 17;

   logic         MCLK = 1'b0;
   logic         RST_n;
   logic [W-1:0] PxIN, PxIES, PxIE;

   gpio_port_int_if #(.WIDTH(W)) bus ();

   gpio_port_int #(.WIDTH(W), .FILTER_LEN(FL)) dut (
      .MCLK  (MCLK),
      .RST_n (RST_n),
      .PxIN  (PxIN),
      .PxIES (PxIES),
      .PxIE  (PxIE),
      .bus   (bus)
   );

   always #5 MCLK = ~MCLK;

   // Stimulus state for the next cycle; strobes clear themselves after one cycle.
   logic         c_rst, c_we, c_rd;
   logic [W-1:0] c_pin, c_ies, c_ie, c_wdata;

   // Reference model: pin history (ph[0] = level sampled at the previous edge).
   logic [W-1:0] ph [HD];
   logic [W-1:0] m_ifg, m_filt, m_fprev;
   int           m_since;
   int           cyc;

   logic [W+16:0] exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   bit            done    = 1'b0;

   function automatic logic [15:0] vec_of(input logic [W-1:0] q);
      for (int i = 0; i < W; i++)
         if (q[i]) return 16'(2 * (i + 1));
      return 16'h0000;
   endfunction

   task automatic model_edge();
      logic [W-1:0] lvl, lvl_prev, nfilt;
      logic [15:0]  v_pre;
      int           warm_need;
      bit           all_same, hit;
      if (!c_rst) begin
         m_ifg   = '0;
         m_filt  = '0;
         m_fprev = '0;
         m_since = 0;
         for (int j = 0; j < HD; j++) ph[j] = '0;
      end else begin
`ifdef PORT_INT_FILTER_EN
         nfilt = m_filt;
         for (int i = 0; i < W; i++) begin
            all_same = 1'b1;
            for (int j = 1; j <= FL; j++)
               if (ph[j][i] != ph[1][i]) all_same = 1'b0;
            if (all_same) nfilt[i] = ph[1][i];
         end
         lvl       = m_filt;
         lvl_prev  = m_fprev;
         warm_need = FL + 3;
`else
         nfilt     = '0;
         lvl       = ph[1];
         lvl_prev  = ph[2];
         warm_need = 3;
`endif
         v_pre = vec_of(m_ifg & c_ie);
         for (int i = 0; i < W; i++) begin
            hit = (m_since >= warm_need) &&
                  (c_ies[i] ? (!lvl[i] && lvl_prev[i]) : (lvl[i] && !lvl_prev[i]));
            if (hit)                                          m_ifg[i] = 1'b1;
            else if (c_we)                                    m_ifg[i] = c_wdata[i];
            else if (c_rd && v_pre != 0 && i == v_pre / 2 - 1) m_ifg[i] = 1'b0;
         end
         m_fprev = m_filt;
         m_filt  = nfilt;
         for (int j = HD - 1; j > 0; j--) ph[j] = ph[j - 1];
         ph[0] = c_pin;
         m_since++;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge MCLK);
         RST_n         = c_rst;
         PxIN          = c_pin;
         PxIES         = c_ies;
         PxIE          = c_ie;
         bus.ifg_we    = c_we;
         bus.ifg_wdata = c_wdata;
         bus.iv_rd     = c_rd;
         model_edge();
         exp_q.push_back({m_ifg, vec_of(m_ifg & c_ie), |(m_ifg & c_ie)});
         c_we = 1'b0;
         c_rd = 1'b0;
      end
   endtask

   task automatic clear_flags();
      c_we    = 1'b1;
      c_wdata = '0;
      tick(1);
   endtask

   // Monitor: one expected entry per clock, compared after the edge settles.
   initial begin
      logic [W+16:0] e, got;
      cyc = 0;
      while (!done) begin
         @(posedge MCLK);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus.PxIFG, bus.PxIV, bus.IRQ};
            n_tests++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL outputs cyc=%0d got ifg=%h iv=%h irq=%b required ifg=%h iv=%h irq=%b",
                        cyc, got[W+16:17], got[16:1], got[0], e[W+16:17], e[16:1], e[0]);
            end
         end
      end
   end

   initial begin
      c_rst = 1'b0; c_pin = '1; c_ies = '0; c_ie = '0;
      c_we = 1'b0; c_wdata = '0; c_rd = 1'b0;
      RST_n = 1'b0; PxIN = '1; PxIES = '0; PxIE = '0;
      bus.ifg_we = 1'b0; bus.ifg_wdata = '0; bus.iv_rd = 1'b0;
      m_ifg = '0; m_filt = '0; m_fprev = '0; m_since = 0;
      for (int j = 0; j < HD; j++) ph[j] = '0;

      // Pins high through reset must not produce flags.
      tick(3);
      c_rst = 1'b1;
      tick(10);

      // Rising edge on bit 0, then falling edge ignored.
      c_pin = '0; tick(6);
      c_ies = 8'h00; c_ie = 8'h01;
      c_pin = 8'h01; tick(8);
      c_pin = 8'h00; tick(8);

      // Falling edge on bit 3 with interrupt disabled, then enabled.
      clear_flags();
      c_ies = 8'h08; c_ie = 8'h00;
      c_pin = 8'h08; tick(8);
      c_pin = 8'h00; tick(8);
      c_ie  = 8'h08; tick(2);

      // IV-read priority clearing.
      c_we = 1'b1; c_wdata = 8'h84; tick(1);
      c_ie = 8'hFF; tick(1);
      c_rd = 1'b1; tick(1);
      tick(1);
      c_rd = 1'b1; tick(1);
      tick(1);
      c_rd = 1'b1; tick(2);

      // Hardware set coinciding with a bus clear on bit 2; write beats IV read.
      c_ies = 8'h00; c_pin = 8'h00; tick(8);
      c_pin = 8'h04; tick(2);
      c_we = 1'b1; c_wdata = 8'h00; tick(1);
`ifdef PORT_INT_FILTER_EN
      for (int k = 0; k < FL + 1; k++) begin
         c_we = 1'b1; c_wdata = 8'h00; tick(1);
      end
`endif
      tick(2);
      c_we = 1'b1; c_wdata = 8'h03; c_rd = 1'b1; tick(1);
      tick(1);

      // PxIES toggling with static pins.
      clear_flags();
      c_pin = 8'h5A; tick(8);
      clear_flags();
      for (int k = 0; k < 6; k++) begin
         c_ies = ~c_ies; tick(2);
      end

      // Short and long pulses on bit 1.
      clear_flags();
      c_ies = 8'h00; c_pin = 8'h00; tick(8);
      clear_flags();
      c_pin = 8'h02; tick(2);
      c_pin = 8'h00; tick(8);
      c_pin = 8'h02; tick(5);
      c_pin = 8'h00; tick(10);

      // Mid-operation reset drops flags and restarts warm-up.
      c_we = 1'b1; c_wdata = 8'hFF; tick(1);
      c_pin = 8'hFF; c_rst = 1'b0; tick(2);
      c_rst = 1'b1; tick(12);

      // Randomised traffic.
      for (int k = 0; k < 600; k++) begin
         c_rst = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 2) == 0) c_pin = c_pin ^ 8'(1 << $urandom_range(0, W - 1));
         if ($urandom_range(0, 15) == 0) c_ies = 8'($urandom);
         if ($urandom_range(0, 7) == 0)  c_ie  = 8'($urandom);
         c_we    = ($urandom_range(0, 9) == 0);
         c_wdata = 8'($urandom);
         c_rd    = ($urandom_range(0, 4) == 0);
         tick(1);
      end

      c_rst = 1'b1;
      tick(2);
      repeat (4) @(posedge MCLK);
      #2;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_port_int.md
Name: gpio_port_int

Overview:
- Input-side companion to the per-pin GPIO logic. Takes the PxIN levels from one port's pins and synchronises them to MCLK.
- Detects edges on each bit, selected per bit by PxIES, and latches them into PxIFG.
- Produces the port interrupt request and the PxIV priority vector for the CPU interrupt path and the peripheral register bus.

Parameters:
- WIDTH, 8: number of port bits. Legal range 1..8.
- FILTER_LEN, 3: cycles a synchronised level must stay stable before it is accepted. Used only when PORT_INT_FILTER_EN is defined; legal range 2..15.

Ports:
- MCLK  input  1  system clock; all state updates on the rising edge.
- RST_n  input  1  synchronous reset, active low.
- PxIN  input  WIDTH  raw pin levels from the PIN blocks (PxINm); asynchronous to MCLK.
- PxIES  input  WIDTH  edge select per bit: 0 = rising, 1 = falling.
- PxIE  input  WIDTH  interrupt enable per bit.
- ifg_we  input  1  register-bus write strobe for PxIFG.
- ifg_wdata  input  WIDTH  data for a PxIFG write.
- iv_rd  input  1  register-bus read strobe for PxIV.
- PxIFG  output  WIDTH  interrupt flag register.
- PxIV  output  16  interrupt vector; combinational from PxIFG & PxIE.
- IRQ  output  1  port interrupt request: OR of (PxIFG & PxIE).

Behaviour:
- Reset (RST_n low at a clock edge):
  - sync1, sync2, prev and PxIFG all cleared to 0.
  - Warm-up counter set to 0.
  - Resulting outputs: PxIFG = 0, PxIV = 0x0000, IRQ = 0.
- Synchroniser:
  - Per bit, sync1 <= PxIN, then sync2 <= sync1, then prev <= sync2.
- Warm-up:
  - A 2-bit counter increments after reset and saturates at 3.
  - Edge detection is disabled while the counter is below 3.
  - Effect: a pin that is high at reset does not produce a spurious rising edge.
  - A reset asserted mid-operation restarts warm-up and drops all pending flags.
- Edge detect, per bit i:
  - rise_i = sync2 & ~prev; fall_i = ~sync2 & prev.
  - edge_i = PxIES[i] ? fall_i : rise_i.
  - Changing PxIES never sets a flag by itself, because detection compares sampled pin levels only.
- Latency:
  - A PxIN transition set up before edge N is captured in sync1 at N and in sync2 at N+1.
  - The flag is set at edge N+2, so PxIFG and IRQ are high from edge N+2.
- Flags are set on an edge regardless of PxIE. PxIE gates only IRQ and PxIV.
- PxIFG next-state, per bit, in priority order:
  1. edge_i = 1 → set.
  2. ifg_we = 1 → load ifg_wdata[i].
  3. iv_rd = 1 and bit i is the one selected by PxIV → clear.
  4. Otherwise hold.
- Simultaneous events:
  - A hardware set beats a bus clear or an IV-read clear on the same bit in the same cycle; the event is not lost.
  - When ifg_we and iv_rd coincide, ifg_we applies and the IV clear is ignored.
- PxIV:
  - n = lowest index with PxIFG[n] & PxIE[n] = 1; PxIV = 2*(n+1), giving values 0x0002..0x0010.
  - If no bit qualifies, PxIV = 0x0000.
  - An iv_rd when PxIV = 0 has no effect.
- Software writing a 1 to PxIFG sets the flag and raises IRQ if the bit is enabled. This is the software-interrupt use.
- Pin pulses shorter than one MCLK period may be missed. That is accepted behaviour.

Optional Feature:
- Macro: PORT_INT_FILTER_EN.
- When defined:
  - A per-bit stability counter sits between sync2 and the edge logic.
  - A new sync2 level is accepted into a "filtered" register only after it has held for FILTER_LEN consecutive cycles.
  - Edge detection compares filtered against its previous value.
  - Any bounce restarts that bit's counter.
  - Latency grows by FILTER_LEN cycles.
  - Counters and filtered values reset to 0; warm-up then extends to FILTER_LEN + 3 cycles.
- When undefined: no filter logic, with latency exactly as stated in Behaviour.

Test Plan:
1. Reset with PxIN = 0xFF, then hold for 10 cycles → PxIFG stays 0x00, IRQ = 0, PxIV = 0x0000.
2. PxIES = 0x00, PxIE = 0x01; PxIN[0] goes 0→1 before edge N → PxIFG = 0x01 and IRQ = 1 from edge N+2, PxIV = 0x0002; PxIN[0] then goes 1→0 → no new flag.
3. PxIES = 0x08, PxIE = 0x00; falling edge on bit 3 → PxIFG = 0x08, IRQ = 0, PxIV = 0; then set PxIE = 0x08 → IRQ = 1, PxIV = 0x0008.
4. PxIFG = 0x84 with PxIE = 0xFF → PxIV = 0x0006; one iv_rd → PxIFG = 0x80, PxIV = 0x0010; second iv_rd → PxIFG = 0x00, PxIV = 0, IRQ = 0.
5. Bit-2 edge arriving in the same cycle as ifg_we with ifg_wdata = 0x00 → PxIFG[2] = 1 afterwards (set wins). Also: toggle PxIES with PxIN static → no flag.
6. Filter build with FILTER_LEN = 3: a 2-cycle pulse on PxIN[1] → no flag; a 5-cycle pulse → a flag 3 cycles later than in the unfiltered build.
